// File: rtl/hpi_pkg.sv
`default_nettype none
// ============================================================================
// | Package     : hpi_pkg                                                    |
// | Description : Shared types and constants for the EZ-OTG HPI transaction  |
// |               sequencer: operation codes, FSM state encoding, HPI        |
// |               register selects and the phase-counter width.              |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
package hpi_pkg;

  // Width of the per-phase down-counter; every phase length fits in 1..255.
  localparam int CNT_W = 8;

  // HPI register selects driven on from_sw_address.
  localparam logic [1:0] HPI_ADDR_DATA    = 2'd0;
  localparam logic [1:0] HPI_ADDR_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    HPI_OP_WRITE   = 2'b00,
    HPI_OP_READ    = 2'b01,
    HPI_OP_RESET   = 2'b10,
    HPI_OP_ILLEGAL = 2'b11
  } hpi_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RECOVER  = 3'd4,
    ST_RSTPULSE = 3'd5,
    ST_ERR      = 3'd6
  } hpi_state_e;

endpackage
`default_nettype wire

// File: rtl/hpi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// | Module      : hpi_txn_sequencer                                          |
// | Description : Fabric-side master for the EZ-OTG HPI port. Turns single   |
// |               WRITE / READ / chip-RESET requests into timed active-low   |
// |               CS/RD/WR/RST strobe sequences for hpi_io_intf and returns  |
// |               a one-cycle completion pulse (with read data / error).     |
// | Revision    : 1.0 - initial release                                      |
// |--------------------------------------------------------------------------|
// | Ports                                                                    |
// |   Clk, Reset_N          clock, asynchronous active-low reset             |
// |   req_valid/ready       request handshake (ready only in IDLE)           |
// |   req_op/addr/wdata     operation, HPI register select, write data       |
// |   rsp_valid/rdata/err   completion pulse, read data (held), illegal-op   |
// |   busy                  sequencer not idle                               |
// |   from_sw_address       register select to hpi_io_intf                   |
// |   from_sw_data_out      write data to hpi_io_intf                        |
// |   from_sw_data_in       registered OTG data from hpi_io_intf             |
// |   from_sw_r/w/cs/reset  active-low strobes to hpi_io_intf                |
// ============================================================================
module hpi_txn_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 3,
  parameter int RECOVER_CYC = 2,
  parameter int RD_LAT      = 2,
  parameter int RST_CYC     = 16
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  from_sw_address,
  output logic [15:0] from_sw_data_out,
  input  logic [15:0] from_sw_data_in,
  output logic        from_sw_r,
  output logic        from_sw_w,
  output logic        from_sw_cs,
  output logic        from_sw_reset
);

  // --------------------------------------------------------------------------
  // Parameter sanity checks
  // --------------------------------------------------------------------------
  generate
    if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_bad_setup
      $error("hpi_txn_sequencer: SETUP_CYC must be in 1..255");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 255) begin : g_bad_strobe
      $error("hpi_txn_sequencer: STROBE_CYC must be in 1..255");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
      $error("hpi_txn_sequencer: HOLD_CYC must be in 1..255");
    end
    if (RECOVER_CYC < 0 || RECOVER_CYC > 255) begin : g_bad_recover
      $error("hpi_txn_sequencer: RECOVER_CYC must be in 0..255");
    end
    if (RD_LAT < 1 || RD_LAT > 255) begin : g_bad_rdlat
      $error("hpi_txn_sequencer: RD_LAT must be in 1..255");
    end
    if (RST_CYC < 1 || RST_CYC > 255) begin : g_bad_rst
      $error("hpi_txn_sequencer: RST_CYC must be in 1..255");
    end
    if (HOLD_CYC < RD_LAT) begin : g_bad_hold_lat
      $error("hpi_txn_sequencer: HOLD_CYC must be >= RD_LAT");
    end
  endgenerate

  // Counter load values: a phase of N cycles loads N-1 and ends at zero.
  localparam logic [CNT_W-1:0] c_setup_ld  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_strobe_ld = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] c_hold_ld   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] c_rec_ld    = CNT_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] c_rst_ld    = CNT_W'(RST_CYC - 1);
  // HOLD cycle index RD_LAT-1 corresponds to this count value, i.e. the
  // cycle where data sampled while RD was low reaches from_sw_data_in.
  localparam logic [CNT_W-1:0] c_cap_cnt   = CNT_W'(HOLD_CYC - RD_LAT);

  hpi_state_e       r_state;
  hpi_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  hpi_op_e          r_op;
  hpi_op_e          w_req_op;
  logic             w_accept;
  logic             w_rsp_done;
  logic             w_ill;

  assign w_req_op  = hpi_op_e'(req_op);
  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // State register and phase counter
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    w_ill       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          case (w_req_op)
            HPI_OP_WRITE, HPI_OP_READ: begin
              w_state_nxt = ST_SETUP;
              w_cnt_nxt   = c_setup_ld;
            end
            HPI_OP_RESET: begin
              w_state_nxt = ST_RSTPULSE;
              w_cnt_nxt   = c_rst_ld;
            end
            default: begin
              w_state_nxt = ST_ERR;
              w_cnt_nxt   = '0;
              w_ill       = 1'b1;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = c_strobe_ld;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_hold_ld;
        end
      end
      ST_HOLD, ST_RSTPULSE: begin
        if (r_cnt == '0) begin
          w_rsp_done = 1'b1;
          if (RECOVER_CYC > 0) begin
            w_state_nxt = ST_RECOVER;
            w_cnt_nxt   = c_rec_ld;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_RECOVER: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Strobes and response flags are registered from the next state so they
  // line up with the state register and never glitch on the HPI pins.
  // The latched op is safe here: STROBE is only ever entered from SETUP.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      from_sw_cs    <= 1'b1;
      from_sw_r     <= 1'b1;
      from_sw_w     <= 1'b1;
      from_sw_reset <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      from_sw_cs    <= !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                         (w_state_nxt == ST_HOLD));
      from_sw_r     <= !((w_state_nxt == ST_STROBE) && (r_op == HPI_OP_READ));
      from_sw_w     <= !((w_state_nxt == ST_STROBE) && (r_op == HPI_OP_WRITE));
      from_sw_reset <= (w_state_nxt != ST_RSTPULSE);
      rsp_valid     <= w_rsp_done | w_ill;
      rsp_err       <= w_ill;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch and read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_op             <= HPI_OP_WRITE;
      from_sw_address  <= '0;
      from_sw_data_out <= '0;
      rsp_rdata        <= '0;
    end else begin
      if (w_accept) begin
        r_op <= w_req_op;
        if ((w_req_op == HPI_OP_WRITE) || (w_req_op == HPI_OP_READ)) begin
          from_sw_address <= req_addr;
        end
        // data_out only changes for writes; hpi_io_intf gates the bus with w.
        if (w_req_op == HPI_OP_WRITE) begin
          from_sw_data_out <= req_wdata;
        end
      end
      if ((r_state == ST_HOLD) && (r_op == HPI_OP_READ) && (r_cnt == c_cap_cnt)) begin
        rsp_rdata <= from_sw_data_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// | Module      : tb_hpi_txn_sequencer                                       |
// | Description : Self-checking bench for hpi_txn_sequencer. Includes a      |
// |               register model of hpi_io_intf and an OTG register stub,    |
// |               a transaction-level timeline model checked every cycle,    |
// |               directed scenarios and a randomized request stream.        |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_hpi_txn_sequencer;
  import hpi_pkg::*;

  localparam int S   = 2;
  localparam int T   = 4;
  localparam int H   = 3;
  localparam int R   = 2;
  localparam int RST = 16;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [1:0]  req_addr = 2'b00;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  from_sw_address;
  logic [15:0] from_sw_data_out;
  logic [15:0] from_sw_data_in;
  logic        from_sw_r;
  logic        from_sw_w;
  logic        from_sw_cs;
  logic        from_sw_reset;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  hpi_txn_sequencer dut (
    .Clk              (Clk),
    .Reset_N          (Reset_N),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .busy             (busy),
    .from_sw_address  (from_sw_address),
    .from_sw_data_out (from_sw_data_out),
    .from_sw_data_in  (from_sw_data_in),
    .from_sw_r        (from_sw_r),
    .from_sw_w        (from_sw_w),
    .from_sw_cs       (from_sw_cs),
    .from_sw_reset    (from_sw_reset)
  );

  // --------------------------------------------------------------------------
  // hpi_io_intf model (output register + input register) and OTG stub
  // --------------------------------------------------------------------------
  logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n;
  logic [1:0]  otg_addr;
  logic [15:0] otg_dout;
  logic [15:0] otg_data;
  logic [15:0] stub_mem [4] = '{16'hBEEF, 16'h0101, 16'h0202, 16'h0303};

  always @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      otg_cs_n        <= 1'b1;
      otg_rd_n        <= 1'b1;
      otg_wr_n        <= 1'b1;
      otg_rst_n       <= 1'b1;
      otg_addr        <= 2'b00;
      otg_dout        <= 16'h0000;
      from_sw_data_in <= 16'h0000;
    end else begin
      otg_cs_n        <= from_sw_cs;
      otg_rd_n        <= from_sw_r;
      otg_wr_n        <= from_sw_w;
      otg_rst_n       <= from_sw_reset;
      otg_addr        <= from_sw_address;
      otg_dout        <= from_sw_data_out;
      from_sw_data_in <= otg_data;
    end
  end

  assign otg_data = (!otg_cs_n && !otg_rd_n) ? stub_mem[otg_addr] : otg_dout;

  always @(posedge Clk) begin
    if (!otg_cs_n && !otg_wr_n) stub_mem[otg_addr] <= otg_dout;
  end

  // --------------------------------------------------------------------------
  // Comparison helper
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model: each accepted request defines a timeline in
  // cycles after its accept cycle; outputs are derived from those windows.
  // --------------------------------------------------------------------------
  int          cyc_n = 0;
  bit          m_active = 0;
  bit          m_have = 0;
  int          m_ta = 0;
  int          m_len = 0;
  int          m_rspk = 0;
  logic [1:0]  m_op = 2'b00;
  logic [1:0]  m_addr = 2'b00;
  logic [15:0] m_dout = 16'h0000;
  logic [15:0] m_rdata = 16'h0000;
  logic [15:0] m_rexp = 16'h0000;
  logic [15:0] m_mem [4] = '{16'hBEEF, 16'h0101, 16'h0202, 16'h0303};

  always @(negedge Clk) begin
    int k;
    bit bus, e_cs, e_r, e_w, e_rst, e_v, e_err;
    cyc_n++;
    if (!Reset_N) begin
      m_active = 0;
      m_have   = 0;
      m_addr   = 2'b00;
      m_dout   = 16'h0000;
      m_rdata  = 16'h0000;
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {from_sw_cs, from_sw_r, from_sw_w, from_sw_reset}, 4'hF);
      chk("rst_rsp", {rsp_valid, rsp_err}, 0);
      chk("rst_addr", from_sw_address, 0);
      chk("rst_dout", from_sw_data_out, 0);
      chk("rst_rdata", rsp_rdata, 0);
    end else begin
      k = m_have ? (cyc_n - m_ta) : 0;
      if (m_active && k > m_len) m_active = 0;
      bus   = m_active && (m_op == HPI_OP_WRITE || m_op == HPI_OP_READ);
      e_cs  = !(bus && k <= S + T + H);
      e_w   = !(bus && m_op == HPI_OP_WRITE && k > S && k <= S + T);
      e_r   = !(bus && m_op == HPI_OP_READ && k > S && k <= S + T);
      e_rst = !(m_active && m_op == HPI_OP_RESET && k <= RST);
      e_v   = m_have && (k == m_rspk);
      e_err = e_v && (m_op == HPI_OP_ILLEGAL);
      chk("m_ready", req_ready, !m_active);
      chk("m_busy", busy, m_active);
      chk("m_cs", from_sw_cs, e_cs);
      chk("m_r", from_sw_r, e_r);
      chk("m_w", from_sw_w, e_w);
      chk("m_reset", from_sw_reset, e_rst);
      chk("m_rsp_valid", rsp_valid, e_v);
      chk("m_rsp_err", rsp_err, e_err);
      chk("m_addr", from_sw_address, m_addr);
      chk("m_dout", from_sw_data_out, m_dout);
      if (e_v && m_op == HPI_OP_READ) m_rdata = m_rexp;
      if (!(m_active && m_op == HPI_OP_READ) || e_v) chk("m_rdata", rsp_rdata, m_rdata);
      chk("inv_rw_both_low", !from_sw_r && !from_sw_w, 0);
      chk("inv_strobe_cs_high", (!from_sw_r || !from_sw_w) && from_sw_cs, 0);
      chk("inv_ready_busy", req_ready, !busy);
      if (!m_active && req_valid) begin
        m_active = 1;
        m_have   = 1;
        m_ta     = cyc_n;
        m_op     = req_op;
        case (req_op)
          HPI_OP_WRITE, HPI_OP_READ: begin
            m_len  = S + T + H + R;
            m_rspk = S + T + H + 1;
            m_addr = req_addr;
            if (req_op == HPI_OP_WRITE) begin
              m_dout           = req_wdata;
              m_mem[req_addr]  = req_wdata;
            end else begin
              m_rexp = m_mem[req_addr];
            end
          end
          HPI_OP_RESET: begin
            m_len  = RST + R;
            m_rspk = RST + 1;
          end
          default: begin
            m_len  = 1;
            m_rspk = 1;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed driver: one request, dropped after accept, measured until the
  // sequencer is ready again. k counts cycles after the accept cycle.
  // --------------------------------------------------------------------------
  task automatic run_one(input logic [1:0] op, input logic [1:0] addr, input logic [15:0] wd,
                         output int ncs, output int nw, output int nr, output int nrst,
                         output int first_stb, output int rsp_k, output int rdy_k,
                         output logic err, output logic [15:0] rd, output logic dout_ok);
    int k;
    bit acc;
    ncs = 0; nw = 0; nr = 0; nrst = 0; first_stb = -1; rsp_k = -1; rdy_k = -1;
    err = 1'b0; rd = 16'h0; dout_ok = 1'b1; acc = 0; k = 0;
    @(posedge Clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (acc) begin
        k++;
        if (req_ready) begin
          rdy_k = k;
          break;
        end
        ncs  += int'(!from_sw_cs);
        nw   += int'(!from_sw_w);
        nr   += int'(!from_sw_r);
        nrst += int'(!from_sw_reset);
        if ((!from_sw_w || !from_sw_r) && first_stb < 0) first_stb = k;
        if (!from_sw_cs && from_sw_data_out !== wd) dout_ok = 1'b0;
        if (rsp_valid && rsp_k < 0) begin
          rsp_k = k;
          err   = rsp_err;
          rd    = rsp_rdata;
        end
      end else if (req_ready) begin
        acc = 1;
        @(posedge Clk); #1;
        req_valid = 1'b0;
      end
    end
    if (rdy_k < 0) begin
      req_valid = 1'b0;
      chk("run_one_timeout", 0, 1);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int ncs, nw, nr, nrst, fst, rk, yk, cs_hi, got, nrsp;
    logic err, dok;
    logic [15:0] rd;
    bit fire;

    #2 Reset_N = 1'b0;
    #20 Reset_N = 1'b1;
    repeat (2) @(posedge Clk);

    // 1: WRITE addr 2
    run_one(HPI_OP_WRITE, 2'd2, 16'h1234, ncs, nw, nr, nrst, fst, rk, yk, err, rd, dok);
    chk("t1_cs_low", ncs, 9);
    chk("t1_w_low", nw, 4);
    chk("t1_r_low", nr, 0);
    chk("t1_w_start", fst, 3);
    chk("t1_dout_stable", dok, 1);
    chk("t1_rsp_k", rk, 10);
    chk("t1_rsp_err", err, 0);
    chk("t1_ready_k", yk, 12);

    // 2: READ addr 0, stub holds BEEF
    run_one(HPI_OP_READ, 2'd0, 16'h0000, ncs, nw, nr, nrst, fst, rk, yk, err, rd, dok);
    chk("t2_r_low", nr, 4);
    chk("t2_w_low", nw, 0);
    chk("t2_rdata", rd, 16'hBEEF);
    chk("t2_rsp_k", rk, 10);

    // 3: chip RESET
    run_one(HPI_OP_RESET, 2'd0, 16'h0000, ncs, nw, nr, nrst, fst, rk, yk, err, rd, dok);
    chk("t3_rst_low", nrst, 16);
    chk("t3_cs_low", ncs, 0);
    chk("t3_rsp_k", rk, 17);
    chk("t3_ready_k", yk, 19);

    // 4: back-to-back WRITE then READ with req_valid held
    @(posedge Clk); #1;
    req_valid = 1'b1; req_op = HPI_OP_WRITE; req_addr = 2'd3; req_wdata = 16'h5A5A;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (req_ready) begin
        got = i;
        break;
      end
    end
    chk("t4_first_accept", got >= 0, 1);
    @(posedge Clk); #1;
    req_op = HPI_OP_READ;
    got = -1; cs_hi = 0;
    for (int k = 1; k < 40; k++) begin
      @(negedge Clk);
      if (req_ready) begin
        got = k;
        break;
      end
      cs_hi += int'(from_sw_cs);
    end
    chk("t4_second_accept_k", got, 12);
    chk("t4_cs_high", cs_hi, 2);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    wait_idle("t4_idle");
    chk("t4_rdata", rsp_rdata, 16'h5A5A);

    // 5: illegal op
    run_one(HPI_OP_ILLEGAL, 2'd1, 16'hFFFF, ncs, nw, nr, nrst, fst, rk, yk, err, rd, dok);
    chk("t5_rsp_k", rk, 1);
    chk("t5_rsp_err", err, 1);
    chk("t5_no_strobes", ncs + nw + nr + nrst, 0);
    chk("t5_ready_k", yk, 2);

    // 6: reset during STROBE of a WRITE
    @(posedge Clk); #1;
    req_valid = 1'b1; req_op = HPI_OP_WRITE; req_addr = 2'd1; req_wdata = 16'hA5A5;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (req_ready) begin
        got = i;
        break;
      end
    end
    chk("t6_accept", got >= 0, 1);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    repeat (5) @(negedge Clk);
    chk("t6_w_low_before", from_sw_w, 0);
    #2 Reset_N = 1'b0;
    #1;
    chk("t6_async_strobes", {from_sw_cs, from_sw_r, from_sw_w, from_sw_reset}, 4'hF);
    chk("t6_async_rsp", rsp_valid, 0);
    repeat (3) @(posedge Clk);
    #2 Reset_N = 1'b1;
    nrsp = 0;
    repeat (15) @(negedge Clk) nrsp += int'(rsp_valid);
    chk("t6_no_rsp", nrsp, 0);
    run_one(HPI_OP_READ, 2'd1, 16'h0000, ncs, nw, nr, nrst, fst, rk, yk, err, rd, dok);
    chk("t6_read_rdata", rd, 16'hA5A5);
    chk("t6_read_rsp_k", rk, 10);

    // Randomized stream, checked by the timeline model every cycle
    for (int c = 0; c < 2500; c++) begin
      @(negedge Clk);
      fire = req_valid && req_ready;
      @(posedge Clk); #1;
      if (fire || !req_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          int sel;
          sel       = $urandom_range(0, 9);
          req_op    = (sel < 4) ? HPI_OP_WRITE : (sel < 8) ? HPI_OP_READ :
                      (sel == 8) ? HPI_OP_RESET : HPI_OP_ILLEGAL;
          req_addr  = 2'($urandom_range(0, 3));
          req_wdata = 16'($urandom);
          req_valid = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    wait_idle("rand_final_idle");
    repeat (3) @(posedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
